arb_prims_2ph: RTL and testbench

Clocked library block bundling the three primitives of the single-rail 2-phase arbiter: a 2-input Muller C-element, a 2-way mutual-exclusion element and a toggle element. Each primitive is modelled as synchronous logic on one clock, so the arbiter datapath can run on FPGA/ASIC flows without hand-placed asynchronous cells. The primitives are independent; the enclosing arbiter wires them together with external XOR gates.

---
 rtl/arb_prims_2ph_if.sv | 23 ++
 rtl/arb_prims_2ph.sv | 105 ++++++++++
 tb/tb_arb_prims_2ph.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/arb_prims_2ph_if.sv
// rtl/arb_prims_2ph_if.sv - signal bundle for the 2-phase arbiter primitives
interface arb_prims_2ph_if;
  logic c_a;
  logic c_b;
  logic c_z;
  logic mx_r1;
  logic mx_r2;
  logic mx_g1;
  logic mx_g2;
  logic tg_in;
  logic tg_dot;
  logic tg_blank;

  modport master (
    output c_a, c_b, mx_r1, mx_r2, tg_in,
    input  c_z, mx_g1, mx_g2, tg_dot, tg_blank
  );

  modport slave (
    input  c_a, c_b, mx_r1, mx_r2, tg_in,
    output c_z, mx_g1, mx_g2, tg_dot, tg_blank
  );
endinterface

// File: rtl/arb_prims_2ph.sv
// rtl/arb_prims_2ph.sv - clocked C-element, mutex and toggle primitives
module arb_prims_2ph (
  input  logic           clk,
  input  logic           rstn,
  arb_prims_2ph_if.slave bus
);

  // Grant bits are the state bits, so the grants come straight from flops
  // and the one-hot-or-zero encoding keeps both grants from ever being high.
  typedef enum logic [1:0] {
    MX_IDLE = 2'b00,
    MX_G1   = 2'b01,
    MX_G2   = 2'b10
  } mx_state_t;

  mx_state_t mx_state;
  mx_state_t mx_next;
  logic      last_g2;
  logic      last_g2_next;

  logic      c_z_q;
  logic      tg_in_q;
  logic      tg_phase;
  logic      tg_dot_q;
  logic      tg_blank_q;
  logic      tg_event;

  // C-element: follow the inputs only when they agree.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_z_q <= 1'b0;
    end else if (bus.c_a == bus.c_b) begin
      c_z_q <= bus.c_a;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mx_state <= MX_IDLE;
      last_g2  <= 1'b1;
    end else begin
      mx_state <= mx_next;
      last_g2  <= last_g2_next;
    end
  end

  always_comb begin
    mx_next      = mx_state;
    last_g2_next = last_g2;
    case (mx_state)
      MX_IDLE: begin
        // On a tie the side that did not win last time gets the grant.
        if (bus.mx_r1 && (!bus.mx_r2 || last_g2)) begin
          mx_next      = MX_G1;
          last_g2_next = 1'b0;
        end else if (bus.mx_r2) begin
          mx_next      = MX_G2;
          last_g2_next = 1'b1;
        end
      end
      MX_G1: begin
        if (!bus.mx_r1) begin
          mx_next = MX_IDLE;
        end
      end
      MX_G2: begin
        if (!bus.mx_r2) begin
          mx_next = MX_IDLE;
        end
      end
      default: begin
        mx_next = MX_IDLE;
      end
    endcase
  end

  // Toggle: each input transition alternately flips dot then blank.
  assign tg_event = bus.tg_in ^ tg_in_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tg_in_q    <= 1'b0;
      tg_phase   <= 1'b0;
      tg_dot_q   <= 1'b0;
      tg_blank_q <= 1'b0;
    end else begin
      tg_in_q <= bus.tg_in;
      if (tg_event) begin
        tg_phase <= ~tg_phase;
        if (!tg_phase) begin
          tg_dot_q <= ~tg_dot_q;
        end else begin
          tg_blank_q <= ~tg_blank_q;
        end
      end
    end
  end

  assign bus.c_z      = c_z_q;
  assign bus.mx_g1    = mx_state[0];
  assign bus.mx_g2    = mx_state[1];
  assign bus.tg_dot   = tg_dot_q;
  assign bus.tg_blank = tg_blank_q;

endmodule

// File: tb/tb_arb_prims_2ph.sv
// tb/tb_arb_prims_2ph.sv - randomized self-checking bench for arb_prims_2ph
module tb_arb_prims_2ph;

  logic clk;
  logic rstn;
  int   tests;
  int   failed;

  // reference state
  int   m_z;
  int   m_owner;
  int   m_last;
  int   m_events;
  int   m_prev_in;

  arb_prims_2ph_if bus ();

  arb_prims_2ph dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_z       = 0;
    m_owner   = 0;
    m_last    = 2;
    m_events  = 0;
    m_prev_in = 0;
  endtask

  task automatic model_step();
    if (bus.c_a == bus.c_b) m_z = int'(bus.c_a);
    if (m_owner == 1 && !bus.mx_r1) m_owner = 0;
    else if (m_owner == 2 && !bus.mx_r2) m_owner = 0;
    else if (m_owner == 0) begin
      if (bus.mx_r1 && bus.mx_r2) m_owner = 3 - m_last;
      else if (bus.mx_r1) m_owner = 1;
      else if (bus.mx_r2) m_owner = 2;
      if (m_owner != 0) m_last = m_owner;
    end
    if (int'(bus.tg_in) != m_prev_in) m_events++;
    m_prev_in = int'(bus.tg_in);
  endtask

  task automatic check_model();
    check("c_z", bus.c_z, m_z[0]);
    check("mx_g1", bus.mx_g1, m_owner == 1);
    check("mx_g2", bus.mx_g2, m_owner == 2);
    check("mx_excl", bus.mx_g1 & bus.mx_g2, 1'b0);
    check("tg_dot", bus.tg_dot, ((m_events + 1) / 2) % 2 == 1);
    check("tg_blank", bus.tg_blank, (m_events / 2) % 2 == 1);
  endtask

  // Inputs are set just after a falling edge; one rising edge, then compare.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check("rst_c_z", bus.c_z, 1'b0);
    check("rst_g1", bus.mx_g1, 1'b0);
    check("rst_g2", bus.mx_g2, 1'b0);
    check("rst_dot", bus.tg_dot, 1'b0);
    check("rst_blank", bus.tg_blank, 1'b0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rstn   = 1'b1;
    bus.c_a = 0; bus.c_b = 0; bus.mx_r1 = 0; bus.mx_r2 = 0; bus.tg_in = 0;
    model_reset();
    do_reset();

    // toggle sequence
    bus.tg_in = 1; cycle(); check("tg_seq1", {bus.tg_dot, bus.tg_blank} == 2'b10, 1'b1);
    bus.tg_in = 0; cycle(); check("tg_seq2", {bus.tg_dot, bus.tg_blank} == 2'b11, 1'b1);
    bus.tg_in = 1; cycle(); check("tg_seq3", {bus.tg_dot, bus.tg_blank} == 2'b01, 1'b1);
    bus.tg_in = 0; cycle(); check("tg_seq4", {bus.tg_dot, bus.tg_blank} == 2'b00, 1'b1);

    // C-element
    bus.c_a = 1; bus.c_b = 0; cycle(); check("c_10", bus.c_z, 1'b0);
    bus.c_a = 1; bus.c_b = 1; cycle(); check("c_11", bus.c_z, 1'b1);
    bus.c_a = 0; bus.c_b = 1; cycle(); check("c_01", bus.c_z, 1'b1);
    bus.c_a = 0; bus.c_b = 0; cycle(); check("c_00", bus.c_z, 1'b0);

    // single request pulse of three cycles
    bus.mx_r1 = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("single_g1", bus.mx_g1, 1'b1); check("single_g2", bus.mx_g2, 1'b0);
    end
    bus.mx_r1 = 0; cycle(); check("single_rel", bus.mx_g1, 1'b0);

    // contention from reset
    do_reset();
    bus.mx_r1 = 1; bus.mx_r2 = 1;
    cycle(); check("tie1_g1", bus.mx_g1, 1'b1);
    cycle(); check("tie1_hold", bus.mx_g1, 1'b1);
    bus.mx_r1 = 0;
    cycle(); check("hand_gap", bus.mx_g1 | bus.mx_g2, 1'b0);
    cycle(); check("hand_g2", bus.mx_g2, 1'b1);
    bus.mx_r2 = 0; cycle(); check("g2_rel", bus.mx_g2, 1'b0);
    bus.mx_r1 = 1; bus.mx_r2 = 1;
    cycle(); check("tie2_g1", bus.mx_g1, 1'b1);
    bus.mx_r1 = 0; cycle(); cycle(); check("tie2_g2", bus.mx_g2, 1'b1);
    bus.mx_r2 = 0; cycle();

    // reset while g2 and tg_dot are high, r1 held across release
    bus.mx_r2 = 1; bus.tg_in = 1; cycle();
    check("pre_g2", bus.mx_g2, 1'b1); check("pre_dot", bus.tg_dot, 1'b1);
    bus.mx_r1 = 1;
    do_reset();
    bus.mx_r2 = 0;
    cycle(); check("post_g1", bus.mx_g1, 1'b1); check("post_dot", bus.tg_dot, 1'b1);
    bus.mx_r1 = 0; cycle();

    // randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      bus.c_a = 1'($urandom_range(1, 0));
      bus.c_b = 1'($urandom_range(1, 0));
      if (!bus.mx_r1) bus.mx_r1 = ($urandom_range(2, 0) == 0);
      else if (m_owner == 1) bus.mx_r1 = ($urandom_range(2, 0) != 0);
      if (!bus.mx_r2) bus.mx_r2 = ($urandom_range(2, 0) == 0);
      else if (m_owner == 2) bus.mx_r2 = ($urandom_range(2, 0) != 0);
      if ($urandom_range(1, 0) == 1) bus.tg_in = ~bus.tg_in;
      if ($urandom_range(63, 0) == 0) do_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
